// File: rtl/rs_pkg.sv
// Shared constants, FSM state type and a GF(2^m) constant-multiply helper
// for the Reed-Solomon encoder datapath.
package rs_pkg;

  localparam int         SYM_W_DEF = 4;
  localparam int         N_DEF     = 15;
  localparam int         K_DEF     = 11;
  localparam logic [8:0] PRIM_DEF  = 9'h13;

  // g(x) for RS(15,11), roots a^1..a^4 over x^4+x+1, packed g[3..0]; x^4 implicit
  localparam logic [15:0] GEN_15_11 = {4'd13, 4'd12, 4'd8, 4'd7};

  typedef enum logic {
    ST_MSG = 1'b0,
    ST_PAR = 1'b1
  } rs_state_e;

  // sym * coef in GF(2^m); m is the degree of prim (highest set bit).
  // Evaluated at elaboration to build the constant-multiplier XOR matrices.
  function automatic logic [7:0] gf_mul_const(logic [7:0] sym, logic [7:0] coef,
                                              logic [8:0] prim);
    logic [7:0] acc;
    logic [7:0] a;
    int         w;
    w = 1;
    for (int i = 1; i < 9; i++) begin
      if (prim[i]) w = i;
    end
    acc = '0;
    a   = sym;
    for (int i = 0; i < 8; i++) begin
      if (i < w) begin
        if (coef[i]) acc = acc ^ a;
        if (a[w-1]) a = (a << 1) ^ prim[7:0];
        else        a = a << 1;
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/gf_const_mult.sv
// Combinational multiply by a fixed GF(2^SYM_W) coefficient.
// Column i of the matrix is COEF * x^i, so the product is the XOR of the
// columns selected by the set bits of the input symbol.
module gf_const_mult
  import rs_pkg::*;
#(
  parameter int               SYM_W     = 4,
  parameter logic [SYM_W-1:0] COEF      = '0,
  parameter logic [8:0]       PRIM_POLY = 9'h13
) (
  input  logic [SYM_W-1:0] sym_i,
  output logic [SYM_W-1:0] prod_o
);

  logic [SYM_W-1:0] col [SYM_W];

  for (genvar gi = 0; gi < SYM_W; gi++) begin : g_col
    localparam logic [7:0] COL_FULL = gf_mul_const(8'(1 << gi), 8'(COEF), PRIM_POLY);
    assign col[gi] = COL_FULL[SYM_W-1:0];
  end

  // XOR together the matrix columns picked by the input bits
  always_comb begin
    prod_o = '0;
    for (int i = 0; i < SYM_W; i++) begin
      if (sym_i[i]) prod_o = prod_o ^ col[i];
    end
  end

endmodule

// File: rtl/rs_encoder_stream.sv
// Systematic Reed-Solomon encoder on a valid/ready stream. Message symbols
// pass straight through while an LFSR divides by g(x); the NPAR remainder
// symbols are then shifted out as parity. One registered output stage that
// holds while the sink stalls.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   ST_MSG | accepting message symbols, forwarding them, updating LFSR
//   ST_PAR | input stalled, shifting parity p[NPAR-1] out, LFSR drains to 0
module rs_encoder_stream
  import rs_pkg::*;
#(
  parameter int                     SYM_W     = SYM_W_DEF,
  parameter int                     N         = N_DEF,
  parameter int                     K         = K_DEF,
  parameter logic [8:0]             PRIM_POLY = PRIM_DEF,
  parameter logic [SYM_W*(N-K)-1:0] GEN       = GEN_15_11
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SYM_W-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SYM_W-1:0] out_data,
  output logic             out_parity,
  output logic             out_last
);

  localparam int NPAR  = N - K;
  localparam int CNT_W = $clog2(N + 1);

  rs_state_e        state_q, state_d;
  logic [SYM_W-1:0] p_q [NPAR];
  logic [SYM_W-1:0] p_d [NPAR];
  logic [CNT_W-1:0] msg_cnt_q, msg_cnt_d;
  logic [CNT_W-1:0] par_cnt_q, par_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [SYM_W-1:0] out_data_q, out_data_d;
  logic             out_parity_q, out_parity_d;
  logic             out_last_q, out_last_d;

  logic [SYM_W-1:0] fb;
  logic [SYM_W-1:0] prod [NPAR];
  logic             ocan;
  logic             accept;

  assign fb     = in_data ^ p_q[NPAR-1];
  assign ocan   = ~out_valid_q | out_ready;
  assign in_ready = (state_q == ST_MSG) & ocan;
  assign accept = in_valid & in_ready;

  for (genvar gi = 0; gi < NPAR; gi++) begin : g_mult
    gf_const_mult #(
      .SYM_W    (SYM_W),
      .COEF     (GEN[gi*SYM_W +: SYM_W]),
      .PRIM_POLY(PRIM_POLY)
    ) u_mult (
      .sym_i (fb),
      .prod_o(prod[gi])
    );
  end

  // Next-state: message passthrough with LFSR update, then parity shift-out
  always_comb begin
    state_d      = state_q;
    p_d          = p_q;
    msg_cnt_d    = msg_cnt_q;
    par_cnt_d    = par_cnt_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_parity_d = out_parity_q;
    out_last_d   = out_last_q;

    // Output slot frees up when it was empty or just consumed
    if (ocan) out_valid_d = 1'b0;

    case (state_q)
      ST_MSG: begin
        if (accept) begin
          out_valid_d  = 1'b1;
          out_data_d   = in_data;
          out_parity_d = 1'b0;
          out_last_d   = 1'b0;
          p_d[0]       = prod[0];
          for (int i = 1; i < NPAR; i++) p_d[i] = p_q[i-1] ^ prod[i];
          // A frame closes at K symbols even without in_last
          if (in_last || (msg_cnt_q == CNT_W'(K - 1))) begin
            msg_cnt_d = '0;
            state_d   = ST_PAR;
          end else begin
            msg_cnt_d = msg_cnt_q + 1'b1;
          end
        end
      end
      ST_PAR: begin
        if (ocan) begin
          out_valid_d  = 1'b1;
          out_data_d   = p_q[NPAR-1];
          out_parity_d = 1'b1;
          out_last_d   = 1'b0;
          p_d[0]       = '0;
          for (int i = 1; i < NPAR; i++) p_d[i] = p_q[i-1];
          // Zero shift-in leaves p all-zero for the next frame
          if (par_cnt_q == CNT_W'(NPAR - 1)) begin
            out_last_d = 1'b1;
            par_cnt_d  = '0;
            state_d    = ST_MSG;
          end else begin
            par_cnt_d = par_cnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  // State, LFSR, counters and output register with synchronous reset
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= ST_MSG;
      for (int i = 0; i < NPAR; i++) p_q[i] <= '0;
      msg_cnt_q    <= '0;
      par_cnt_q    <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_parity_q <= 1'b0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      p_q          <= p_d;
      msg_cnt_q    <= msg_cnt_d;
      par_cnt_q    <= par_cnt_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_parity_q <= out_parity_d;
      out_last_q   <= out_last_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_parity = out_parity_q;
  assign out_last   = out_last_q;

endmodule

// File: tb/tb_rs_encoder_stream.sv
// Directed bench for rs_encoder_stream: default RS(15,11)/GF(16) instance
// and an RS(255,239)/GF(256) instance. Expected codewords come from a
// polynomial long-division model; outputs are collected at the clock edge.
module tb_rs_encoder_stream;

  function automatic int gmul(int a_in, int b, int w, int prim);
    int r;
    int a;
    r = 0;
    a = a_in;
    for (int i = 0; i < w; i++) begin
      if (b[i]) r = r ^ a;
      a = a << 1;
      if (a[w]) a = a ^ prim;
    end
    return r;
  endfunction

  // g(x) = prod_{i=1..16} (x + a^i) over x^8+x^4+x^3+x^2+1, packed g[15..0]
  function automatic logic [127:0] gen_poly8();
    int         c [17];
    int         root;
    logic [127:0] g;
    for (int d = 0; d < 17; d++) c[d] = 0;
    c[0] = 1;
    root = 1;
    g = '0;
    for (int i = 1; i <= 16; i++) begin
      root = gmul(root, 2, 8, 'h11D);
      for (int d = i; d >= 1; d--) c[d] = c[d-1] ^ gmul(c[d], root, 8, 'h11D);
      c[0] = gmul(c[0], root, 8, 'h11D);
    end
    for (int j = 0; j < 16; j++) g[j*8 +: 8] = c[j][7:0];
    return g;
  endfunction

  localparam logic [127:0] GEN_B = gen_poly8();

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid_a, in_valid_b, in_last;
  logic [7:0] in_data;
  logic       in_ready_a, in_ready_b;
  logic       out_valid_a, out_valid_b;
  logic       out_ready_a, out_ready_b;
  logic [3:0] out_data_a;
  logic [7:0] out_data_b;
  logic       out_parity_a, out_parity_b, out_last_a, out_last_b;
  bit         bp_en;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         ga [4];
  int         gb [16];
  logic [8:0] tx [$];
  logic [9:0] exp_q [$];
  logic [9:0] oq_a [$];
  logic [9:0] oq_b [$];
  logic [9:0] cur_a, cur_b, hold_a, hold_b;
  bit         stall_a, stall_b;

  always #5 clk = ~clk;

  rs_encoder_stream dut_a (
    .sys_clk(clk), .sys_rst(rst),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data[3:0]), .in_last(in_last),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
    .out_parity(out_parity_a), .out_last(out_last_a)
  );

  rs_encoder_stream #(
    .SYM_W(8), .N(255), .K(239), .PRIM_POLY(9'h11D), .GEN(GEN_B)
  ) dut_b (
    .sys_clk(clk), .sys_rst(rst),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .out_parity(out_parity_b), .out_last(out_last_b)
  );

  assign cur_a = {out_last_a, out_parity_a, 4'b0000, out_data_a};
  assign cur_b = {out_last_b, out_parity_b, out_data_b};

  always @(negedge clk) begin
    out_ready_a = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    out_ready_b = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Collect accepted outputs and check hold-while-stalled
  always @(posedge clk) begin
    if (rst) begin
      stall_a = 1'b0;
      stall_b = 1'b0;
    end else begin
      if (stall_a) begin
        n_tests++;
        assert (out_valid_a === 1'b1 && cur_a === hold_a) else begin
          n_fail++;
          $error("FAIL stall_hold_a: got v=%0b %0h, expected v=1 %0h", out_valid_a, cur_a, hold_a);
        end
      end
      if (stall_b) begin
        n_tests++;
        assert (out_valid_b === 1'b1 && cur_b === hold_b) else begin
          n_fail++;
          $error("FAIL stall_hold_b: got v=%0b %0h, expected v=1 %0h", out_valid_b, cur_b, hold_b);
        end
      end
      if (out_valid_a && out_ready_a) oq_a.push_back(cur_a);
      if (out_valid_b && out_ready_b) oq_b.push_back(cur_b);
      stall_a = out_valid_a && !out_ready_a;
      stall_b = out_valid_b && !out_ready_b;
      hold_a  = cur_a;
      hold_b  = cur_b;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int gcoef(int sel, int idx);
    return sel != 0 ? gb[idx] : ga[idx];
  endfunction

  function automatic logic rdy(int sel);
    return sel != 0 ? in_ready_b : in_ready_a;
  endfunction

  function automatic int qsize(int sel);
    return sel != 0 ? oq_b.size() : oq_a.size();
  endfunction

  function automatic logic [9:0] qget(int sel, int i);
    return sel != 0 ? oq_b[i] : oq_a[i];
  endfunction

  // kind: 0 random, 1 all zero, 2 zeros then a final 1
  task automatic add_frame(input int sel, input int len, input int kind,
                           input bit with_last, input bit do_model);
    int w;
    int prim;
    int np;
    int m [$];
    int b [$];
    w    = sel != 0 ? 8 : 4;
    prim = sel != 0 ? 'h11D : 'h13;
    np   = sel != 0 ? 16 : 4;
    for (int i = 0; i < len; i++) begin
      int v;
      case (kind)
        0:       v = int'($urandom_range(0, (1 << w) - 1));
        1:       v = 0;
        default: v = (i == len - 1) ? 1 : 0;
      endcase
      m.push_back(v);
      tx.push_back({with_last && (i == len - 1), 8'(v)});
    end
    if (do_model) begin
      b = m;
      for (int j = 0; j < np; j++) b.push_back(0);
      for (int i = 0; i < len; i++) begin
        int c;
        c = b[i];
        if (c != 0) begin
          for (int j = 1; j <= np; j++) b[i+j] = b[i+j] ^ gmul(c, gcoef(sel, np - j), w, prim);
        end
      end
      for (int i = 0; i < len; i++) exp_q.push_back({2'b00, 8'(m[i])});
      for (int j = 0; j < np; j++) exp_q.push_back({(j == np - 1), 1'b1, 8'(b[len+j])});
    end
  endtask

  task automatic send(input int sel);
    while (tx.size() > 0) begin
      int guard;
      logic [8:0] s;
      guard = 0;
      s = tx.pop_front();
      in_data = s[7:0];
      in_last = s[8];
      if (sel != 0) in_valid_b = 1'b1;
      else          in_valid_a = 1'b1;
      #1;
      while (!rdy(sel) && guard < 1000) begin
        @(negedge clk);
        #1;
        guard++;
      end
      if (guard >= 1000) begin
        n_tests++;
        n_fail++;
        $error("FAIL send_timeout: got no in_ready, expected in_ready=1 within 1000 cycles");
        tx.delete();
      end
      @(negedge clk);
    end
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    in_last    = 1'b0;
  endtask

  task automatic drain(input int sel, input string tag);
    int guard;
    int n;
    guard = 0;
    while (qsize(sel) < exp_q.size() && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    repeat (5) @(negedge clk);
    chk({tag, "_count"}, 32'(qsize(sel)), 32'(exp_q.size()));
    n = qsize(sel) < exp_q.size() ? qsize(sel) : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_sym%0d", tag, i), 32'(qget(sel, i)), 32'(exp_q[i]));
    oq_a.delete();
    oq_b.delete();
    exp_q.delete();
  endtask

  initial begin
    int guard;
    ga = '{7, 8, 12, 13};
    for (int j = 0; j < 16; j++) gb[j] = int'(GEN_B[j*8 +: 8]);
    rst = 1'b1;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    in_last = 1'b0;
    in_data = '0;
    bp_en = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_out_valid_a", 32'(out_valid_a), 0);
    chk("rst_out_data_a", 32'(out_data_a), 0);
    chk("rst_out_parity_a", 32'(out_parity_a), 0);
    chk("rst_out_last_a", 32'(out_last_a), 0);
    chk("rst_in_ready_a", 32'(in_ready_a), 1);
    chk("rst_out_valid_b", 32'(out_valid_b), 0);
    chk("rst_in_ready_b", 32'(in_ready_b), 1);
    rst = 1'b0;
    @(negedge clk);

    // 1: all-zero message -> all-zero codeword, parity on 12..15, last on 15th
    add_frame(0, 11, 1, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) exp_q.push_back({(i == 14), (i >= 11), 8'h00});
    send(0);
    drain(0, "zero");

    // 2: message x^0 -> parity equals g coefficients 13,12,8,7
    add_frame(0, 11, 2, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) exp_q.push_back(10'h000);
    exp_q.push_back({2'b00, 8'd1});
    exp_q.push_back({2'b01, 8'd13});
    exp_q.push_back({2'b01, 8'd12});
    exp_q.push_back({2'b01, 8'd8});
    exp_q.push_back({2'b11, 8'd7});
    send(0);
    drain(0, "unit");

    // 3: random frames with ~50% backpressure
    bp_en = 1'b1;
    for (int f = 0; f < 3; f++) add_frame(0, 11, 0, 1'b1, 1'b1);
    send(0);
    drain(0, "rand_bp");
    bp_en = 1'b0;

    // 4: shortened frame then a full frame back-to-back
    add_frame(0, 5, 0, 1'b1, 1'b1);
    add_frame(0, 11, 0, 1'b1, 1'b1);
    send(0);
    drain(0, "short");

    // in_last after K symbols: frame forced closed at 11, then a 1-symbol frame
    add_frame(0, 11, 0, 1'b0, 1'b1);
    add_frame(0, 1, 0, 1'b1, 1'b1);
    send(0);
    drain(0, "force_k");

    // 5: reset during parity after 2 parity symbols
    add_frame(0, 11, 0, 1'b1, 1'b0);
    send(0);
    guard = 0;
    while (oq_a.size() < 13 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("rst_mid_reach", 32'(oq_a.size() >= 13), 1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_mid_out_valid", 32'(out_valid_a), 0);
    chk("rst_mid_in_ready", 32'(in_ready_a), 1);
    chk("rst_mid_out_parity", 32'(out_parity_a), 0);
    rst = 1'b0;
    oq_a.delete();
    oq_b.delete();
    @(negedge clk);
    add_frame(0, 11, 0, 1'b1, 1'b1);
    send(0);
    drain(0, "after_rst");

    // 6: RS(255,239) over GF(256) with backpressure
    bp_en = 1'b1;
    for (int f = 0; f < 3; f++) add_frame(1, 239, 0, 1'b1, 1'b1);
    send(1);
    drain(1, "rs255");
    bp_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
